// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: branch type codes,
// 2-bit counter encodings and the prediction record carried down the pipe.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BGE      = 3'd4,
        BLTU     = 3'd5,
        BGEU     = 3'd6
    } branch_type_e;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_INIT  = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    // Saturating step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken) return (c == CTR_ST)  ? c : c + 2'd1;
        else       return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing signals of the branch predictor: fetch lookup, ID/EX
// register controls, and the EX resolve/redirect path.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic [31:0]  PCF;
    logic         PredTakenF;
    logic [31:0]  PredTargetF;
    logic         StallD, FlushD;
    logic         StallE, FlushE;
    branch_type_e BranchTypeE;
    logic         BranchE;
    logic [31:0]  PCE;
    logic [31:0]  BranchTargetE;
    logic         MispredictE;
    logic [31:0]  RedirectPCE;

    modport master (
        output PCF, StallD, FlushD, StallE, FlushE,
               BranchTypeE, BranchE, PCE, BranchTargetE,
        input  PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );

    modport slave (
        input  PCF, StallD, FlushD, StallE, FlushE,
               BranchTypeE, BranchE, PCE, BranchTargetE,
        output PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );

endinterface

// File: rtl/branch_predictor_branch_target_table.sv
// Direct-mapped BTB storage: two async read ports (fetch and EX), one
// synchronous write port, asynchronous clear to the cold state.
module branch_target_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx_a,
    output logic               rd_valid_a,
    output logic [TAG_W-1:0]   rd_tag_a,
    output logic [31:0]        rd_target_a,
    output logic [1:0]         rd_ctr_a,
    input  logic [INDEX_W-1:0] rd_idx_b,
    output logic               rd_valid_b,
    output logic [TAG_W-1:0]   rd_tag_b,
    output logic [31:0]        rd_target_b,
    output logic [1:0]         rd_ctr_b,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_valid,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_target,
    input  logic [1:0]         wr_ctr
);

    logic [ENTRIES-1:0]             valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag;
    logic [ENTRIES-1:0][31:0]       target;
    logic [ENTRIES-1:0][1:0]        ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            tag    <= '0;
            target <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
        end else if (wr_en) begin
            valid[wr_idx]  <= wr_valid;
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
            ctr[wr_idx]    <= wr_ctr;
        end
    end

    // Reads see the pre-write contents in the cycle of a write.
    assign rd_valid_a  = valid[rd_idx_a];
    assign rd_tag_a    = tag[rd_idx_a];
    assign rd_target_a = target[rd_idx_a];
    assign rd_ctr_a    = ctr[rd_idx_a];
    assign rd_valid_b  = valid[rd_idx_b];
    assign rd_tag_b    = tag[rd_idx_b];
    assign rd_target_b = target[rd_idx_b];
    assign rd_ctr_b    = ctr[rd_idx_b];

endmodule

// File: rtl/branch_predictor.sv
// BTB-based dynamic branch predictor: fetch lookup, ID/EX shadow of the
// prediction, EX mispredict detection and table training.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int INDEX_W = $clog2(ENTRIES),
    localparam int TAG_W   = 30 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);

    logic [INDEX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]   tag_f, tag_e;
    logic               f_valid, e_valid;
    logic [TAG_W-1:0]   f_tag, e_tag;
    logic [31:0]        f_target, e_target;
    logic [1:0]         f_ctr, e_ctr;
    logic               hit_f, hit_e, is_br;
    pred_t              pred_f, pred_d, pred_e;

    logic               wr_en, wr_valid;
    logic [TAG_W-1:0]   wr_tag;
    logic [31:0]        wr_target;
    logic [1:0]         wr_ctr;

    assign idx_f = bp.PCF[INDEX_W+1:2];
    assign tag_f = bp.PCF[31:INDEX_W+2];
    assign idx_e = bp.PCE[INDEX_W+1:2];
    assign tag_e = bp.PCE[31:INDEX_W+2];

    branch_target_table #(
        .ENTRIES(ENTRIES), .INDEX_W(INDEX_W), .TAG_W(TAG_W)
    ) u_tbl (
        .clk(clk), .rst_n(rst_n),
        .rd_idx_a(idx_f), .rd_valid_a(f_valid), .rd_tag_a(f_tag),
        .rd_target_a(f_target), .rd_ctr_a(f_ctr),
        .rd_idx_b(idx_e), .rd_valid_b(e_valid), .rd_tag_b(e_tag),
        .rd_target_b(e_target), .rd_ctr_b(e_ctr),
        .wr_en(wr_en), .wr_idx(idx_e), .wr_valid(wr_valid),
        .wr_tag(wr_tag), .wr_target(wr_target), .wr_ctr(wr_ctr)
    );

    assign hit_f = f_valid && (f_tag == tag_f);
    assign hit_e = e_valid && (e_tag == tag_e);
    assign is_br = (bp.BranchTypeE != NOBRANCH);

    always_comb begin
        pred_f.taken  = hit_f & f_ctr[1];
        pred_f.target = pred_f.taken ? f_target : 32'd0;
    end

    assign bp.PredTakenF  = pred_f.taken;
    assign bp.PredTargetF = pred_f.target;

    // Flush wins over stall in both shadow stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_d <= '0;
            pred_e <= '0;
        end else begin
            if (bp.FlushD)       pred_d <= '0;
            else if (!bp.StallD) pred_d <= pred_f;
            if (bp.FlushE)       pred_e <= '0;
            else if (!bp.StallE) pred_e <= pred_d;
        end
    end

    always_comb begin
        bp.MispredictE = 1'b0;
        bp.RedirectPCE = bp.PCE + 32'd4;
        if (is_br) begin
            bp.MispredictE = (bp.BranchE != pred_e.taken) ||
                             (bp.BranchE && pred_e.taken && (pred_e.target != bp.BranchTargetE));
            if (bp.BranchE) bp.RedirectPCE = bp.BranchTargetE;
        end else if (pred_e.taken) begin
            // Stale entry predicted taken on a non-branch: fall through.
            bp.MispredictE = 1'b1;
        end
    end

    // Training is gated by StallE so a held branch updates exactly once.
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = e_valid;
        wr_tag    = tag_e;
        wr_target = e_target;
        wr_ctr    = e_ctr;
        if (!bp.StallE) begin
            if (is_br) begin
                if (hit_e) begin
                    wr_en  = 1'b1;
                    wr_ctr = ctr_next(e_ctr, bp.BranchE);
                    if (bp.BranchE) wr_target = bp.BranchTargetE;
                end else if (bp.BranchE) begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_target = bp.BranchTargetE;
                    wr_ctr    = CTR_ALLOC;
                end
            end else if (hit_e) begin
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor, checked against a
// table-level behavioural model of the predictor.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    branch_predictor_if bus();
    branch_predictor #(.ENTRIES(N)) dut (.clk(clk), .rst_n(rst_n), .bp(bus));

    // Behavioural model
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    bit          d_tk, e_tk;
    logic [31:0] d_tg, e_tg;

    logic [31:0] pc_pool  [8] = '{32'h100, 32'h140, 32'h104, 32'h180,
                                  32'h200, 32'h1000, 32'h108, 32'h300};
    logic [31:0] tgt_pool [4] = '{32'h180, 32'h1C0, 32'h200, 32'h400};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        d_tk = 0; e_tk = 0; d_tg = 0; e_tg = 0;
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        int i = int'((pc >> 2) % N);
        return m_valid[i] && (m_tag[i] == (pc >> 6));
    endfunction

    task automatic model_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int i = int'((pc >> 2) % N);
        tk = m_hit(pc) && (m_ctr[i] >= 2);
        tg = tk ? m_tgt[i] : 32'd0;
    endtask

    task automatic drive(input logic [31:0] pcf, input int bt, input bit br,
                         input logic [31:0] pce, input logic [31:0] tgt);
        bus.PCF = pcf; bus.BranchTypeE = branch_type_e'(bt); bus.BranchE = br;
        bus.PCE = pce; bus.BranchTargetE = tgt;
        bus.StallD = 0; bus.FlushD = 0; bus.StallE = 0; bus.FlushE = 0;
    endtask

    // Check outputs mid-cycle, then advance model and DUT across one edge.
    task automatic step();
        bit ptk, nd_tk, ne_tk, mis;
        logic [31:0] ptg, nd_tg, ne_tg, red;
        int i;
        @(negedge clk);
        model_predict(bus.PCF, ptk, ptg);
        chk("PredTakenF", bus.PredTakenF, ptk);
        chk("PredTargetF", bus.PredTargetF, ptg);
        red = bus.PCE + 4;
        if (bus.BranchTypeE != NOBRANCH) begin
            mis = (bus.BranchE != e_tk) || (bus.BranchE && e_tk && e_tg != bus.BranchTargetE);
            if (bus.BranchE) red = bus.BranchTargetE;
        end else mis = e_tk;
        chk("MispredictE", bus.MispredictE, mis);
        chk("RedirectPCE", bus.RedirectPCE, red);
        nd_tk = bus.FlushD ? 0 : bus.StallD ? d_tk : ptk;
        nd_tg = bus.FlushD ? 0 : bus.StallD ? d_tg : ptg;
        ne_tk = bus.FlushE ? 0 : bus.StallE ? e_tk : d_tk;
        ne_tg = bus.FlushE ? 0 : bus.StallE ? e_tg : d_tg;
        @(posedge clk);
        #1;
        d_tk = nd_tk; d_tg = nd_tg; e_tk = ne_tk; e_tg = ne_tg;
        i = int'((bus.PCE >> 2) % N);
        if (!bus.StallE) begin
            if (bus.BranchTypeE != NOBRANCH) begin
                if (m_hit(bus.PCE)) begin
                    m_ctr[i] = bus.BranchE ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1)
                                           : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
                    if (bus.BranchE) m_tgt[i] = bus.BranchTargetE;
                end else if (bus.BranchE) begin
                    m_valid[i] = 1; m_tag[i] = bus.PCE >> 6;
                    m_tgt[i] = bus.BranchTargetE; m_ctr[i] = 2;
                end
            end else if (m_hit(bus.PCE)) m_valid[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive(32'h0, 0, 0, 32'h0, 32'h0);
        #12;
        chk("rst_PredTakenF", bus.PredTakenF, 1'b0);
        chk("rst_PredTargetF", bus.PredTargetF, 32'h0);
        chk("rst_MispredictE", bus.MispredictE, 1'b0);
        chk("rst_RedirectPCE", bus.RedirectPCE, 32'h4);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Cold miss allocates the taken branch
        drive(32'h0, 1, 1, 32'h100, 32'h180);
        #1;
        chk("cold_mis", bus.MispredictE, 1'b1);
        chk("cold_redir", bus.RedirectPCE, 32'h180);
        step();
        drive(32'h100, 0, 0, 32'h500, 32'h0);
        #1;
        chk("cold_hit_tk", bus.PredTakenF, 1'b1);
        chk("cold_hit_tg", bus.PredTargetF, 32'h180);
        step();

        // Saturate up, then walk down to weak-NT
        repeat (3) begin drive(32'h100, 1, 1, 32'h100, 32'h180); step(); end
        repeat (2) begin drive(32'h100, 1, 0, 32'h100, 32'h180); step(); end
        drive(32'h100, 0, 0, 32'h500, 32'h0);
        #1;
        chk("sat_down_tk", bus.PredTakenF, 1'b0);
        step();

        // Aliasing on index 0
        drive(32'h140, 0, 0, 32'h500, 32'h0);
        #1;
        chk("alias_miss", bus.PredTakenF, 1'b0);
        step();
        drive(32'h140, 2, 1, 32'h140, 32'h1C0); step();
        drive(32'h100, 0, 0, 32'h500, 32'h0);
        #1;
        chk("alias_old_miss", bus.PredTakenF, 1'b0);
        step();

        // Target change on a hit
        drive(32'h140, 2, 1, 32'h140, 32'h200); step();
        drive(32'h140, 0, 0, 32'h500, 32'h0);
        #1;
        chk("tgt_change", bus.PredTargetF, 32'h200);
        step();

        // Taken branch held in EX for three cycles, predicted-taken flushed in D
        drive(32'h140, 2, 1, 32'h140, 32'h200); step();
        drive(32'h140, 2, 1, 32'h140, 32'h200); bus.FlushD = 1; step();
        repeat (3) begin drive(32'h140, 2, 1, 32'h140, 32'h1C0); bus.StallE = 1; bus.StallD = 1; step(); end
        drive(32'h140, 2, 1, 32'h140, 32'h1C0); step();

        // Async reset mid-cycle drops the prediction before the next edge
        drive(32'h140, 0, 0, 32'h500, 32'h0);
        #1;
        chk("pre_rst_tk", bus.PredTakenF, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_tk", bus.PredTakenF, 1'b0);
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin drive(pc_pool[k], 0, 0, 32'h500, 32'h0); step(); end

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            drive(pc_pool[$urandom_range(0, 7)],
                  ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 6)) : 0,
                  bit'($urandom_range(0, 1)),
                  pc_pool[$urandom_range(0, 7)],
                  tgt_pool[$urandom_range(0, 3)]);
            bus.StallD = ($urandom_range(0, 9) == 0);
            bus.StallE = ($urandom_range(0, 9) == 0);
            bus.FlushD = ($urandom_range(0, 14) == 0);
            bus.FlushE = ($urandom_range(0, 14) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
